// File: rtl/can_fifo_pkg.sv
// Shared defaults and the frame-info entry layout for the CAN FD receive FIFO.
package can_fifo_pkg;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_DEPTH           = 128;
    localparam int DEF_INFO_DEPTH      = 32;
    localparam int DEF_MAX_FRAME_WORDS = 18;
    localparam int DEF_AF_LEVEL        = 110;
    localparam int LEN_W               = $clog2(DEF_MAX_FRAME_WORDS + 1);

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             overrun;
    } info_t;
endpackage

// File: rtl/can_fifo_ram.sv
// Simple storage array: synchronous write, asynchronous read, contents never reset.
module can_fifo_ram #(
    parameter int W = 32,
    parameter int N = 128,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/can_fd_rx_fifo.sv
// Receive FIFO holding whole CAN FD frames: words are staged until commit, dropped on abort,
// and the oldest committed frame is read by offset and popped as a unit.
module can_fd_rx_fifo
    import can_fifo_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int INFO_DEPTH      = DEF_INFO_DEPTH,
    parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS,
    parameter int AF_LEVEL        = DEF_AF_LEVEL
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               reset_mode,
    input  logic                               wr,
    input  logic [DATA_W-1:0]                  data_in,
    input  logic                               commit,
    input  logic                               abort,
    input  logic                               release_buffer,
    input  logic [$clog2(MAX_FRAME_WORDS)-1:0] rd_offset,
    output logic [DATA_W-1:0]                  data_out,
    output logic [$clog2(MAX_FRAME_WORDS+1)-1:0] frame_len,
    output logic                               overrun,
    output logic                               info_empty,
    output logic [$clog2(INFO_DEPTH):0]        info_cnt,
    output logic [$clog2(DEPTH):0]             fifo_cnt,
    output logic                               almost_full,
    output logic [7:0]                         drop_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IW  = $clog2(INFO_DEPTH);
    localparam int LW  = $clog2(MAX_FRAME_WORDS + 1);
    localparam int CW  = AW + 1;
    localparam int ICW = IW + 1;

    logic [AW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [IW-1:0] wr_info_ptr, rd_info_ptr;
    logic [LW-1:0] len_cnt;
    logic          latch_overrun;
    logic          commit_q;

    logic          commit_go, frame_empty, info_full, info_push, frame_drop;
    logic          discard, frame_close, wr_ok, wr_refused, rel_go;
    logic [LW-1:0] len_eff, rel_len;
    logic [AW-1:0] base_ptr;
    logic [CW-1:0] fifo_cnt_next;
    logic [ICW-1:0] info_cnt_next;
    info_t         info_wr, info_rd;

    // commit takes effect one cycle late so a word written alongside it joins the frame;
    // abort in either cycle wins and the frame is discarded without counting a drop.
    assign commit_go   = commit_q & ~abort;
    assign frame_empty = (len_cnt == '0) & ~latch_overrun;
    assign info_full   = (info_cnt == ICW'(INFO_DEPTH));
    assign info_push   = commit_go & ~frame_empty & ~info_full;
    assign frame_drop  = commit_go & ~frame_empty & info_full;
    assign discard     = abort | frame_drop;
    assign frame_close = abort | commit_go;

    // A word arriving while a frame closes starts the next frame, written at the rewound pointer on discard.
    assign len_eff    = frame_close ? '0 : len_cnt;
    assign base_ptr   = discard ? commit_ptr : wr_ptr;
    assign wr_ok      = wr & ~abort & (fifo_cnt < CW'(DEPTH)) & (len_eff < LW'(MAX_FRAME_WORDS));
    assign wr_refused = wr & ~abort & ~wr_ok;

    assign info_empty = (info_cnt == '0);
    assign rel_go     = release_buffer & ~info_empty;
    assign rel_len    = rel_go ? frame_len : '0;

    assign fifo_cnt_next = fifo_cnt - (discard ? CW'(len_cnt) : CW'(0)) + CW'(wr_ok) - CW'(rel_len);
    assign info_cnt_next = info_cnt + ICW'(info_push) - ICW'(rel_go);

    assign info_wr.len     = LEN_W'(len_cnt);
    assign info_wr.overrun = latch_overrun;

    can_fifo_ram #(.W(DATA_W), .N(DEPTH)) u_data_ram (
        .clk   (clk),
        .we    (wr_ok & ~reset_mode),
        .waddr (base_ptr),
        .wdata (data_in),
        .raddr (rd_ptr + AW'(rd_offset)),
        .rdata (data_out)
    );

    can_fifo_ram #(.W($bits(info_t)), .N(INFO_DEPTH)) u_info_ram (
        .clk   (clk),
        .we    (info_push & ~reset_mode),
        .waddr (wr_info_ptr),
        .wdata (info_wr),
        .raddr (rd_info_ptr),
        .rdata (info_rd)
    );

    assign frame_len   = info_empty ? '0 : LW'(info_rd.len);
    assign overrun     = ~info_empty & info_rd.overrun;
    assign almost_full = (fifo_cnt >= CW'(AF_LEVEL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            wr_info_ptr   <= '0;
            rd_info_ptr   <= '0;
            len_cnt       <= '0;
            latch_overrun <= 1'b0;
            commit_q      <= 1'b0;
            fifo_cnt      <= '0;
            info_cnt      <= '0;
            drop_cnt      <= '0;
        end else if (reset_mode) begin
            wr_ptr        <= rd_ptr;
            commit_ptr    <= rd_ptr;
            wr_info_ptr   <= rd_info_ptr;
            len_cnt       <= '0;
            latch_overrun <= 1'b0;
            commit_q      <= 1'b0;
            fifo_cnt      <= '0;
            info_cnt      <= '0;
        end else begin
            wr_ptr        <= base_ptr + AW'(wr_ok);
            len_cnt       <= len_eff + LW'(wr_ok);
            latch_overrun <= (latch_overrun & ~frame_close) | wr_refused;
            commit_q      <= commit & ~abort;
            fifo_cnt      <= fifo_cnt_next;
            info_cnt      <= info_cnt_next;
            if (info_push) begin
                commit_ptr  <= wr_ptr;
                wr_info_ptr <= wr_info_ptr + 1'b1;
            end
            if (rel_go) begin
                rd_ptr      <= rd_ptr + AW'(frame_len);
                rd_info_ptr <= rd_info_ptr + 1'b1;
            end
            if (frame_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
